ip_tx_stream_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares the single IP encapsulator input stream between NUM_SRC TX requesters.
- Each requester presents frames in the encapsulator input format: 5 metadata words, then payload words ending in tlast.
- The block grants one source per frame and holds the grant from the first metadata word through the payload tlast handshake.
- It sits directly upstream of the encapsulator's s_axis port. It provides per-source enable masking, a global pause, and short-frame error flagging.

---
 rtl/ip_tx_pkg.sv | 25 ++
 rtl/rr_priority_picker.sv | 30 +++
 rtl/ip_tx_stream_arbiter.sv | 119 +++++++++++
 tb/tb_ip_tx_stream_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_tx_pkg.sv
// Shared definitions for the IP TX path: arbiter FSM encodings,
// metadata layout of an encapsulator input frame, small helpers.
package ip_tx_pkg;

  // Arbiter FSM state encodings
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_META    = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  // Every frame starts with this many metadata words
  localparam int META_WORDS = 5;

  // Metadata word positions within the frame header
  localparam int META_SRC_IP      = 0;
  localparam int META_DST_IP      = 1;
  localparam int META_PAYLOAD_LEN = 2;
  localparam int META_SRC_PORT    = 3;
  localparam int META_DST_PORT    = 4;

  // Index that follows idx in a ring of n entries
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin find-first: returns the first requesting
// index strictly after ptr, wrapping around the ring of N requesters.
module rr_priority_picker
  import ip_tx_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Walk the ring starting one past ptr; the first hit wins
  always_comb begin
    int c;
    c     = int'(ptr);
    valid = 1'b0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      c = rr_next(c, N);
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/ip_tx_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding the IP encapsulator input.
// One source is granted per frame; the grant is held from the first
// metadata word until the payload tlast handshake.
module ip_tx_stream_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int META_WORDS = ip_tx_pkg::META_WORDS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_SRC*DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_SRC-1:0]              s_axis_tvalid,
  input  logic [NUM_SRC-1:0]              s_axis_tlast,
  output logic [NUM_SRC-1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]         m_axis_tkeep,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  input  logic [NUM_SRC-1:0]              src_enable,
  input  logic                            pause,
  output logic [$clog2(NUM_SRC)-1:0]      grant_id,
  output logic                            busy,
  output logic                            err_short_frame
);
  import ip_tx_pkg::*;

  localparam int IW = $clog2(NUM_SRC);
  localparam int KW = DATA_WIDTH / 8;

  logic [1:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [2:0]    beat_cnt;
  logic          active;
  logic          beat;
  logic [NUM_SRC-1:0] eligible;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
  logic [KW-1:0]         src_keep [NUM_SRC];

  // Unpack the flat per-source buses so the mux can index by grant_id
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_data[g] = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign src_keep[g] = s_axis_tkeep[g*KW +: KW];
  end

  assign active   = (state != ST_IDLE);
  assign eligible = pause ? '0 : (s_axis_tvalid & src_enable);

  rr_priority_picker #(.N(NUM_SRC), .IW(IW)) u_pick (
    .req   (eligible),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Output mux: pure wiring from the granted source, gated while idle
  assign m_axis_tdata  = src_data[grant_id];
  assign m_axis_tkeep  = src_keep[grant_id];
  assign m_axis_tlast  = s_axis_tlast[grant_id];
  assign m_axis_tvalid = active & s_axis_tvalid[grant_id];
  assign beat          = m_axis_tvalid & m_axis_tready;

  // Backpressure reaches only the granted source
  always_comb begin
    s_axis_tready = '0;
    if (active) s_axis_tready[grant_id] = m_axis_tready;
  end

  // Frame FSM: grant in IDLE, count header words, release on tlast
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      rr_ptr          <= IW'(NUM_SRC - 1);
      grant_id        <= '0;
      busy            <= 1'b0;
      err_short_frame <= 1'b0;
      beat_cnt        <= '0;
    end else begin
      err_short_frame <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_idx;
            busy     <= 1'b1;
            beat_cnt <= '0;
            state    <= ST_META;
          end
        end
        ST_META: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 3'd1;
            if (m_axis_tlast) begin
              // Frame ended inside the header: forward it, but flag it
              err_short_frame <= 1'b1;
              rr_ptr          <= grant_id;
              busy            <= 1'b0;
              state           <= ST_IDLE;
            end else if (beat_cnt == 3'(META_WORDS - 1)) begin
              state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (beat && m_axis_tlast) begin
            rr_ptr <= grant_id;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_tx_stream_arbiter.sv
// Scoreboard bench for ip_tx_stream_arbiter: per-source frame queues drive
// the inputs, expected output beats are queued in hand-derived grant order.
module tb_ip_tx_stream_arbiter;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*DW-1:0]  s_axis_tdata;
  logic [NS*KW-1:0]  s_axis_tkeep;
  logic [NS-1:0]     s_axis_tvalid;
  logic [NS-1:0]     s_axis_tlast;
  logic [NS-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [NS-1:0]     src_enable;
  logic              pause;
  logic [1:0]        grant_id;
  logic              busy;
  logic              err_short_frame;

  always #5 clk = ~clk;

  ip_tx_stream_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .META_WORDS(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .src_enable      (src_enable),
    .pause           (pause),
    .grant_id        (grant_id),
    .busy            (busy),
    .err_short_frame (err_short_frame)
  );

  typedef struct {
    int          src;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t       exp_q [$];
  beat_t       src_q [NS][$];
  logic [NS-1:0] hold;
  int checks = 0, failures = 0, mon_beats = 0, err_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Present the head of each source queue on the input buses
  function automatic void drive_src();
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0) begin
        s_axis_tdata[i*DW +: DW] = src_q[i][0].data;
        s_axis_tkeep[i*KW +: KW] = src_q[i][0].keep;
        s_axis_tlast[i]          = src_q[i][0].last;
        s_axis_tvalid[i]         = ~hold[i];
      end else begin
        s_axis_tdata[i*DW +: DW] = '0;
        s_axis_tkeep[i*KW +: KW] = '0;
        s_axis_tlast[i]          = 1'b0;
        s_axis_tvalid[i]         = 1'b0;
      end
    end
  endfunction

  // Source driver: retire words that handshook at the last edge
  initial begin
    logic [NS-1:0] hs;
    forever begin
      @(negedge clk);
      hs = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++)
        if (hs[i]) void'(src_q[i].pop_front());
      drive_src();
    end
  end

  // Monitor: compare every output beat against the scoreboard
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (err_short_frame) err_cnt++;
      if (busy) begin
        chk("tready_others", 32'(s_axis_tready & ~(4'b0001 << grant_id)), 32'd0);
        chk("tready_granted", 32'(s_axis_tready[grant_id]), 32'(m_axis_tready));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        mon_beats++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", m_axis_tdata, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_axis_tdata, e.data);
          chk("beat_keep", 32'(m_axis_tkeep), 32'(e.keep));
          chk("beat_last", 32'(m_axis_tlast), 32'(e.last));
          chk("beat_grant", 32'(grant_id), 32'(e.src));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  // Queue a frame of nw words on source s; optionally expect it on the output
  task automatic load(input int s, input int f, input int nw, input bit pe);
    beat_t b;
    for (int w = 0; w < nw; w++) begin
      b.src  = s;
      b.data = 32'hA000_0000 | (s << 16) | (f << 8) | w;
      b.keep = (w == nw - 1) ? 4'h3 : 4'hF;
      b.last = (w == nw - 1);
      src_q[s].push_back(b);
      if (pe) exp_q.push_back(b);
    end
    drive_src();
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick(1);
      n++;
    end
    chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_grant"}, 32'(grant_id), 32'd0);
    chk({nm, "_err"}, 32'(err_short_frame), 32'd0);
    chk({nm, "_mvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({nm, "_sready"}, 32'(s_axis_tready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, b0, n;
    rst = 1'b1; m_axis_tready = 1'b1; src_enable = 4'hF; pause = 1'b0; hold = '0;
    drive_src();
    tick(2);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Single source 2: 5 meta + 3 payload, back to back at full rate
    load(2, 0, 8, 1);
    tick(1);
    chk("t1_grant", 32'(grant_id), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_mvalid", 32'(m_axis_tvalid), 32'd1);
    tick(7);
    chk("t1_busy_last", 32'(busy), 32'd1);
    tick(1);
    chk("t1_busy_drop", 32'(busy), 32'd0);
    chk("t1_all_out", 32'(exp_q.size()), 32'd0);
    chk("t1_idle_mvalid", 32'(m_axis_tvalid), 32'd0);

    // Fresh pointer, then all four sources requesting: 0,1,2,3,0
    rst = 1'b1; tick(1); rst = 1'b0;
    load(0, 0, 7, 1); load(1, 0, 7, 1); load(2, 0, 7, 1); load(3, 0, 7, 1);
    load(0, 1, 7, 1);
    wait_done(100, "t2");

    // Source 1 under toggling backpressure and a valid gap
    load(1, 0, 9, 1);
    fork
      begin
        repeat (24) begin
          @(posedge clk); #2;
          m_axis_tready = ~m_axis_tready;
        end
        m_axis_tready = 1'b1;
      end
      begin
        tick(13);
        hold[1] = 1'b1; drive_src();
        tick(3);
        hold[1] = 1'b0; drive_src();
      end
    join
    wait_done(100, "t3");

    // Short frame from source 0 (tlast on header word 3), then source 1
    e0 = err_cnt;
    load(0, 0, 4, 1); load(1, 1, 7, 1);
    wait_done(100, "t4");
    chk("t4_err_pulses", 32'(err_cnt - e0), 32'd1);

    // Pause and masking while source 0 is mid-frame
    load(0, 1, 8, 1);
    tick(3);
    pause = 1'b1; src_enable = 4'b1010;
    load(0, 2, 8, 0); load(1, 1, 7, 1); load(2, 1, 7, 0); load(3, 1, 7, 1);
    tick(10);
    chk("t5_frame0_done", 32'(exp_q.size()), 32'd14);
    chk("t5_paused_busy", 32'(busy), 32'd0);
    tick(3);
    chk("t5_still_paused", 32'(busy), 32'd0);
    chk("t5_paused_mvalid", 32'(m_axis_tvalid), 32'd0);
    pause = 1'b0;
    wait_done(100, "t5");
    chk("t5_src0_masked", 32'(src_q[0].size()), 32'd8);
    chk("t5_src2_masked", 32'(src_q[2].size()), 32'd7);

    // Reset in the middle of a payload, then a clean restart
    src_q[0].delete(); src_q[2].delete();
    src_enable = 4'hF; drive_src();
    b0 = mon_beats;
    load(2, 2, 9, 1);
    n = 0;
    while ((mon_beats - b0) < 6 && n < 50) begin tick(1); n++; end
    chk("t6_reached_beat6", 32'(mon_beats - b0), 32'd6);
    rst = 1'b1;
    tick(1);
    chk_reset_outputs("t6_reset");
    src_q[2].delete(); exp_q.delete(); drive_src();
    rst = 1'b0;
    load(0, 3, 7, 1); load(3, 2, 7, 1);
    tick(1);
    chk("t6_first_grant", 32'(grant_id), 32'd0);
    chk("t6_first_busy", 32'(busy), 32'd1);
    wait_done(100, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
